multi_cycle_ctrl: RTL and testbench
===================================

# multi_cycle_ctrl

Multi-cycle control FSM for the RV32I-subset core. It sequences fetch, decode, execute, memory and write-back over the shared single-ported memory and single ALU. It drives the register-file, PC/IR and immediate-generator selects, and the memory request handshake. It also provides a memory-wait watchdog and a retired-instruction counter.

## Interface
- TIMEOUT_CYCLES, 255: consecutive cycles a memory request may wait for mem_ready before abort; legal 1..65535.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- opcode  in  7  IR[6:0] (IR register held in datapath).
- funct3  in  3  IR[14:12].
- funct7b5  in  1  IR[30].
- mem_ready  in  1  memory completes current request this cycle.
- state  out  3  current state (FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4).
- mem_req / mem_we  out  1 / 1  memory request / write qualifier.
- addr_src  out  1  0=PC, 1=ALU result.
- ir_we / pc_we  out  1 / 1  load IR (and old_pc) / load PC+4.
- imm_type  out  2  0=I, 1=S, 2=U.
- alu_a_sel  out  2  0=rs1, 1=old_pc, 2=zero.
- alu_b_sel  out  1  0=rs2, 1=immediate.
- alu_ctrl  out  4  ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLTU=6, SLL=7, SRL=8, SRA=9.
- reg_we / wb_sel  out  1 / 1  register write / 0=ALU, 1=memory data.
- illegal_instr / mem_timeout  out  1 / 1  single-cycle event pulses.
- instret  out  32  retired-instruction count.

## Operation
- Opcodes: R=0110011, I-ALU=0010011, LOAD=0000011, STORE=0100011, AUIPC=0010111, LUI=0110111. All others are illegal.
- FETCH: mem_req=1, addr_src=0. On mem_ready, assert ir_we=1 and pc_we=1 in the same cycle, then go to DECODE. ir_we and pc_we are qualified by mem_ready; they are never asserted without it.
- DECODE: imm_type is driven from opcode (LOAD/I-ALU→I, STORE→S, AUIPC/LUI→U, else 0).
  - Illegal opcode: pulse illegal_instr, go to FETCH, no instret increment.
  - Otherwise go to EXEC.
- EXEC: ALU selects are driven per opcode.
  - R: rs1/rs2. alu_ctrl is decoded from funct3 and funct7b5 (000+b5=SUB, 101+b5=SRA).
  - I-ALU: rs1/imm. 000 is always ADD; 101+b5 is SRA.
  - LOAD/STORE: rs1/imm, ADD.
  - AUIPC: old_pc/imm, ADD.
  - LUI: zero/imm, ADD.
  - LOAD/STORE go to MEM; all others go to WB.
- MEM: mem_req=1, addr_src=1, mem_we=1 for STORE only. ALU selects are held. On mem_ready: LOAD goes to WB; STORE goes to FETCH and increments instret.
- WB: reg_we=1 for exactly one cycle, wb_sel=1 for LOAD, else 0. Go to FETCH and increment instret.
- imm_type, ALU selects and wb_sel hold their decoded values from DECODE through WB.
- Watchdog: a 16-bit wait counter clears on entry to FETCH/MEM and increments each cycle mem_ready=0.
  - Timeout fires when the counter equals TIMEOUT_CYCLES-1 and mem_ready=0.
  - On timeout: pulse mem_timeout, drop mem_req next cycle, go to FETCH.
  - A timeout in FETCH gives no ir_we/pc_we, so the same PC is refetched.
  - A timeout in MEM aborts the instruction with no reg_we and no instret increment.
- mem_ready and timeout in the same cycle: mem_ready wins, no mem_timeout.
- mem_ready outside FETCH/MEM is ignored.
- instret wraps 0xFFFFFFFF→0.

## Timing
- Reset, while high:
  - state=FETCH, wait counter=0, instret=0.
  - All strobes forced 0: mem_req, mem_we, ir_we, pc_we, reg_we, illegal_instr, mem_timeout.
  - Selects=0.
- The first mem_req is asserted in the first cycle after reset deasserts.
- Reset mid-instruction abandons it immediately; no write strobes are asserted in the reset cycle.
- Zero-wait memory (mem_ready in the same cycle as mem_req) cycles per instruction:
  - R/I-ALU/AUIPC/LUI: 4.
  - LOAD: 5.
  - STORE: 4.
  - Illegal: 2.
- Each wait cycle adds one cycle.
- instret updates on the clock edge leaving WB, or leaving MEM for STORE.
- Moore outputs are registered-state decoded; ir_we and pc_we are combinational on mem_ready.

## Test plan
- ADD (0x002081B3), zero-wait memory, 1 cycle after reset:
  - State sequence 0,1,2,4,0.
  - alu_ctrl=0, alu_b_sel=0, reg_we high for exactly one cycle.
  - instret=1.
- SUB (0x402081B3), then SRAI (0x4030D193):
  - SUB: alu_ctrl=1.
  - SRAI: alu_ctrl=9, alu_b_sel=1, imm_type=0.
  - Then LUI: alu_a_sel=2, imm_type=2.
- LW with mem_ready delayed 3 cycles in MEM:
  - mem_req held 4 cycles with addr_src=1, mem_we=0.
  - Then WB with wb_sel=1.
  - Total 8 cycles.
- SW (0x0020A223):
  - MEM cycle has mem_we=1, imm_type=1.
  - No reg_we.
  - instret increments on leaving MEM.
- TIMEOUT_CYCLES=4, mem_ready held low in FETCH:
  - mem_timeout pulses in the 4th wait cycle.
  - No pc_we.
  - FETCH re-entered with mem_req.
- Opcode 0x7F:
  - illegal_instr pulses in DECODE.
  - instret unchanged.
- Reset asserted in EXEC:
  - All strobes 0 during reset.
  - state=0, instret=0 after reset.

Source files
------------

// File: rtl/multi_cycle_ctrl.sv
// rtl/multi_cycle_ctrl.sv - multi-cycle RV32I-subset control FSM with memory watchdog and instret
module multi_cycle_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        mem_ready,
    output logic [2:0]  state,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_src,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  imm_type,
    output logic [1:0]  alu_a_sel,
    output logic        alu_b_sel,
    output logic [3:0]  alu_ctrl,
    output logic        reg_we,
    output logic        wb_sel,
    output logic        illegal_instr,
    output logic        mem_timeout,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q;
    logic [15:0] wait_cnt;
    logic        abort_q;
    logic [31:0] instret_q;
    logic [1:0]  imm_q;
    logic [1:0]  a_sel_q;
    logic        b_sel_q;
    logic [3:0]  ctrl_q;
    logic        load_q;
    logic        store_q;

    logic        dec_legal;
    logic        dec_load;
    logic        dec_store;
    logic [1:0]  dec_imm;
    logic [1:0]  dec_a_sel;
    logic        dec_b_sel;
    logic [3:0]  dec_ctrl;

    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic b5, input logic allow_sub);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (allow_sub && b5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = b5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    always_comb begin
        dec_legal = 1'b1;
        dec_load  = 1'b0;
        dec_store = 1'b0;
        dec_imm   = 2'd0;
        dec_a_sel = 2'd0;
        dec_b_sel = 1'b1;
        dec_ctrl  = ALU_ADD;
        case (opcode)
            OP_R: begin
                dec_b_sel = 1'b0;
                dec_ctrl  = alu_op(funct3, funct7b5, 1'b1);
            end
            OP_I:     dec_ctrl  = alu_op(funct3, funct7b5, 1'b0);
            OP_LOAD:  dec_load  = 1'b1;
            OP_STORE: begin
                dec_store = 1'b1;
                dec_imm   = 2'd1;
            end
            OP_AUIPC: begin
                dec_imm   = 2'd2;
                dec_a_sel = 2'd1;
            end
            OP_LUI: begin
                dec_imm   = 2'd2;
                dec_a_sel = 2'd2;
            end
            default: begin
                dec_legal = 1'b0;
                dec_b_sel = 1'b0;
            end
        endcase
    end

    // The cycle after a timeout is a bubble in FETCH: the request is dropped before a fresh one starts.
    logic waiting;
    logic timeout_hit;
    logic mem_done;
    logic run;
    logic in_body;

    assign run         = ~reset;
    assign waiting     = (state_q == S_FETCH && !abort_q) || state_q == S_MEM;
    assign timeout_hit = waiting && !mem_ready && (wait_cnt == WAIT_LIMIT);
    assign mem_done    = waiting && mem_ready;
    assign in_body     = run && (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            wait_cnt  <= 16'd0;
            abort_q   <= 1'b0;
            instret_q <= 32'd0;
            imm_q     <= 2'd0;
            a_sel_q   <= 2'd0;
            b_sel_q   <= 1'b0;
            ctrl_q    <= 4'd0;
            load_q    <= 1'b0;
            store_q   <= 1'b0;
        end else begin
            abort_q <= timeout_hit;
            if (waiting && !mem_ready && !timeout_hit)
                wait_cnt <= wait_cnt + 16'd1;
            else
                wait_cnt <= 16'd0;

            case (state_q)
                S_FETCH: begin
                    if (mem_done)
                        state_q <= S_DECODE;
                end
                S_DECODE: begin
                    imm_q   <= dec_imm;
                    a_sel_q <= dec_a_sel;
                    b_sel_q <= dec_b_sel;
                    ctrl_q  <= dec_ctrl;
                    load_q  <= dec_load;
                    store_q <= dec_store;
                    state_q <= dec_legal ? S_EXEC : S_FETCH;
                end
                S_EXEC: state_q <= (load_q || store_q) ? S_MEM : S_WB;
                S_MEM: begin
                    if (mem_done) begin
                        if (load_q) begin
                            state_q <= S_WB;
                        end else begin
                            state_q   <= S_FETCH;
                            instret_q <= instret_q + 32'd1;
                        end
                    end else if (timeout_hit) begin
                        state_q <= S_FETCH;
                    end
                end
                S_WB: begin
                    state_q   <= S_FETCH;
                    instret_q <= instret_q + 32'd1;
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

    assign state         = state_q;
    assign instret       = instret_q;
    assign mem_req       = run && waiting;
    assign addr_src      = run && state_q == S_MEM;
    assign mem_we        = run && state_q == S_MEM && store_q;
    assign ir_we         = run && state_q == S_FETCH && !abort_q && mem_ready;
    assign pc_we         = ir_we;
    assign reg_we        = run && state_q == S_WB;
    assign illegal_instr = run && state_q == S_DECODE && !dec_legal;
    assign mem_timeout   = run && timeout_hit;
    assign imm_type      = (run && state_q == S_DECODE) ? dec_imm : (in_body ? imm_q : 2'd0);
    assign alu_a_sel     = in_body ? a_sel_q : 2'd0;
    assign alu_b_sel     = in_body && b_sel_q;
    assign alu_ctrl      = in_body ? ctrl_q : 4'd0;
    assign wb_sel        = in_body && load_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb/tb_multi_cycle_ctrl.sv - directed self-checking bench for multi_cycle_ctrl
module tb_multi_cycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        mem_ready;
    logic [2:0]  state;
    logic        mem_req, mem_we, addr_src, ir_we, pc_we;
    logic [1:0]  imm_type, alu_a_sel;
    logic        alu_b_sel;
    logic [3:0]  alu_ctrl;
    logic        reg_we, wb_sel, illegal_instr, mem_timeout;
    logic [31:0] instret;

    int total = 0;
    int bad   = 0;

    multi_cycle_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .mem_ready(mem_ready), .state(state), .mem_req(mem_req), .mem_we(mem_we),
        .addr_src(addr_src), .ir_we(ir_we), .pc_we(pc_we), .imm_type(imm_type),
        .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_ctrl(alu_ctrl), .reg_we(reg_we),
        .wb_sel(wb_sel), .illegal_instr(illegal_instr), .mem_timeout(mem_timeout), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ir(input logic [31:0] w);
        opcode   = w[6:0];
        funct3   = w[14:12];
        funct7b5 = w[30];
    endtask

    // One cycle spans negedge to negedge; inputs change at negedge, outputs are checked 1 ns later.
    task automatic step(input logic rdy);
        @(negedge clk);
        mem_ready = rdy;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        reset = 1'b1;
        mem_ready = 1'b1;
        set_ir(32'h002081B3);
        step(1);
        step(1);
        chk("rst_state", state, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_ir_we", ir_we, 0);
        chk("rst_pc_we", pc_we, 0);
        chk("rst_reg_we", reg_we, 0);
        chk("rst_instret", instret, 0);

        // ADD
        @(negedge clk);
        reset = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("add_f_state", state, 0);
        chk("add_f_mem_req", mem_req, 1);
        chk("add_f_addr_src", addr_src, 0);
        chk("add_f_ir_we", ir_we, 1);
        chk("add_f_pc_we", pc_we, 1);
        step(0);
        chk("add_d_state", state, 1);
        chk("add_d_imm", imm_type, 0);
        chk("add_d_illegal", illegal_instr, 0);
        step(0);
        chk("add_e_state", state, 2);
        chk("add_e_ctrl", alu_ctrl, 0);
        chk("add_e_bsel", alu_b_sel, 0);
        chk("add_e_asel", alu_a_sel, 0);
        chk("add_e_reg_we", reg_we, 0);
        step(0);
        chk("add_w_state", state, 4);
        chk("add_w_reg_we", reg_we, 1);
        chk("add_w_wb_sel", wb_sel, 0);
        chk("add_w_instret", instret, 0);
        step(1);
        chk("add_end_state", state, 0);
        chk("add_end_reg_we", reg_we, 0);
        chk("add_end_instret", instret, 1);

        // SUB
        set_ir(32'h402081B3);
        step(0);
        step(0);
        chk("sub_e_ctrl", alu_ctrl, 1);
        step(0);
        step(1);
        chk("sub_instret", instret, 2);

        // SRAI
        set_ir(32'h4030D193);
        step(0);
        chk("srai_d_imm", imm_type, 0);
        step(0);
        chk("srai_e_ctrl", alu_ctrl, 9);
        chk("srai_e_bsel", alu_b_sel, 1);
        chk("srai_e_imm", imm_type, 0);
        step(0);
        step(1);
        chk("srai_instret", instret, 3);

        // LUI
        set_ir(32'h123450B7);
        step(0);
        chk("lui_d_imm", imm_type, 2);
        step(0);
        chk("lui_e_asel", alu_a_sel, 2);
        chk("lui_e_imm", imm_type, 2);
        chk("lui_e_bsel", alu_b_sel, 1);
        step(0);
        chk("lui_w_imm", imm_type, 2);
        step(1);
        chk("lui_instret", instret, 4);

        // LW with three MEM wait cycles: 8 cycles from this FETCH to the next
        set_ir(32'h0040A183);
        step(0);
        chk("lw_d_state", state, 1);
        step(0);
        chk("lw_e_state", state, 2);
        for (int i = 0; i < 3; i++) begin
            step(0);
            chk("lw_m_wait_state", state, 3);
            chk("lw_m_wait_req", mem_req, 1);
            chk("lw_m_wait_addr", addr_src, 1);
            chk("lw_m_wait_we", mem_we, 0);
            chk("lw_m_wait_to", mem_timeout, 0);
        end
        step(1);
        chk("lw_m_state", state, 3);
        chk("lw_m_req", mem_req, 1);
        chk("lw_m_addr", addr_src, 1);
        step(0);
        chk("lw_w_state", state, 4);
        chk("lw_w_wb_sel", wb_sel, 1);
        chk("lw_w_reg_we", reg_we, 1);
        step(1);
        chk("lw_end_state", state, 0);
        chk("lw_instret", instret, 5);

        // SW
        set_ir(32'h0020A223);
        step(0);
        chk("sw_d_imm", imm_type, 1);
        step(0);
        step(1);
        chk("sw_m_state", state, 3);
        chk("sw_m_we", mem_we, 1);
        chk("sw_m_imm", imm_type, 1);
        chk("sw_m_reg_we", reg_we, 0);
        chk("sw_m_instret", instret, 5);
        step(1);
        chk("sw_end_state", state, 0);
        chk("sw_end_reg_we", reg_we, 0);
        chk("sw_instret", instret, 6);

        // illegal opcode 0x7F
        set_ir(32'h0000007F);
        step(0);
        chk("ill_d_state", state, 1);
        chk("ill_pulse", illegal_instr, 1);
        // FETCH with mem_ready low: four wait cycles reach the watchdog limit
        step(0);
        chk("ill_end_state", state, 0);
        chk("ill_end_pulse", illegal_instr, 0);
        chk("ill_instret", instret, 6);
        chk("fto_w1_req", mem_req, 1);
        chk("fto_w1_to", mem_timeout, 0);
        step(0);
        chk("fto_w2_to", mem_timeout, 0);
        step(0);
        chk("fto_w3_to", mem_timeout, 0);
        step(0);
        chk("fto_w4_to", mem_timeout, 1);
        chk("fto_w4_pc_we", pc_we, 0);
        chk("fto_w4_ir_we", ir_we, 0);
        step(1);
        chk("fto_gap_state", state, 0);
        chk("fto_gap_req", mem_req, 0);
        chk("fto_gap_pc_we", pc_we, 0);
        chk("fto_gap_to", mem_timeout, 0);
        set_ir(32'h0040A183);
        step(1);
        chk("fto_refetch_state", state, 0);
        chk("fto_refetch_req", mem_req, 1);
        chk("fto_refetch_pc_we", pc_we, 1);

        // LW whose MEM phase times out
        step(0);
        step(0);
        step(0);
        step(0);
        step(0);
        chk("mto_w3_to", mem_timeout, 0);
        step(0);
        chk("mto_w4_state", state, 3);
        chk("mto_w4_to", mem_timeout, 1);
        step(0);
        chk("mto_after_state", state, 0);
        chk("mto_after_req", mem_req, 0);
        chk("mto_after_reg_we", reg_we, 0);
        chk("mto_instret", instret, 6);

        // ADDI interrupted by reset in EXEC
        set_ir(32'h00108093);
        step(1);
        chk("rx_f_ir_we", ir_we, 1);
        step(0);
        step(0);
        chk("rx_e_state", state, 2);
        chk("rx_e_bsel", alu_b_sel, 1);
        @(negedge clk);
        reset = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("rx_rst_reg_we", reg_we, 0);
        chk("rx_rst_mem_req", mem_req, 0);
        chk("rx_rst_ir_we", ir_we, 0);
        chk("rx_rst_mem_we", mem_we, 0);
        chk("rx_rst_bsel", alu_b_sel, 0);
        step(1);
        chk("rx_rst_state", state, 0);
        chk("rx_rst_instret", instret, 0);
        @(negedge clk);
        reset = 1'b0;
        mem_ready = 1'b0;
        #1;
        chk("rx_post_state", state, 0);
        chk("rx_post_req", mem_req, 1);
        chk("rx_post_instret", instret, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
